link_test_ctrl: RTL and testbench

LINK_TEST_CTRL -- requirements
Module: link_test_ctrl

---
 rtl/link_test_ctrl.sv | 151 +++++++++++++++
 tb/tb_link_test_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/link_test_ctrl.sv
// link_test_ctrl: runs a link test by loading seed/payload, pulsing the datapath reset, then waiting for sync with bounded retries.
// Build option: define LINK_TEST_CTRL_SEED_ADVANCE_EN to step the receiver m-sequence seed on every retry.
module link_test_ctrl #(
    parameter int TIMEOUT_CYCLES = 7936,
    parameter int MAX_RETRY      = 3,
    parameter int DATA_LEN       = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4:0]          seed_in,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic                sync_flag,
    input  logic                end_flag,
    output logic                link_rst,
    output logic [4:0]          tx_m_state,
    output logic [4:0]          rx_m_state,
    output logic [DATA_LEN-1:0] test_data,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          attempts
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    // RUN exits as the timer reaches TIMEOUT_CYCLES-1; the RETRY cycle completes the attempt budget.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);
    localparam logic [1:0]         MAX_ATT    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, LOAD, DP_RST, RUN, RETRY, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_rstCnt;
    logic                r_rstHold;
    logic                r_pass;
    logic                r_fail;
    logic [1:0]          r_attempts;
    logic [4:0]          r_txState;
    logic [4:0]          r_rxState;
    logic [DATA_LEN-1:0] r_testData;
    logic [4:0]          w_seed;
    logic [4:0]          w_rxRetry;
    logic                w_runEnd;
    logic                w_canRetry;

    assign w_seed     = (seed_in == 5'd0) ? 5'b00001 : seed_in;
    assign w_runEnd   = (r_timer == TIMER_LAST) || end_flag;
    assign w_canRetry = (r_attempts < MAX_ATT);

`ifdef LINK_TEST_CTRL_SEED_ADVANCE_EN
    // x^5+x^2+1 Fibonacci step so the receiver searches a new phase
    assign w_rxRetry = {r_rxState[3:0], r_rxState[4] ^ r_rxState[1]};
`else
    assign w_rxRetry = r_rxState;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = DP_RST;
            DP_RST:  if (r_rstCnt) w_next = RUN;
            RUN: begin
                if (sync_flag) begin
                    w_next = DONE;
                end else if (w_runEnd) begin
                    w_next = RETRY;
                end
            end
            RETRY:   w_next = w_canRetry ? DP_RST : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_rstHold keeps link_rst high through reset until the first clock edge after release
    always_comb begin
        link_rst   = r_rstHold || (r_state == DP_RST);
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
        pass       = r_pass;
        fail       = r_fail;
        attempts   = r_attempts;
        tx_m_state = r_txState;
        rx_m_state = r_rxState;
        test_data  = r_testData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer    <= '0;
            r_rstCnt   <= 1'b0;
            r_rstHold  <= 1'b1;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_attempts <= 2'd0;
            r_txState  <= 5'b00001;
            r_rxState  <= 5'b00001;
            r_testData <= '0;
        end else begin
            r_rstHold <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pass     <= 1'b0;
                        r_fail     <= 1'b0;
                        r_attempts <= 2'd0;
                    end
                end
                LOAD: begin
                    r_txState  <= w_seed;
                    r_rxState  <= w_seed;
                    r_testData <= data_in;
                    r_attempts <= r_attempts + 2'd1;
                    r_rstCnt   <= 1'b0;
                    r_timer    <= '0;
                end
                DP_RST: begin
                    r_rstCnt <= 1'b1;
                    r_timer  <= '0;
                end
                RUN: begin
                    r_timer <= r_timer + 1'b1;
                    if (sync_flag) begin
                        r_pass <= 1'b1;
                    end
                end
                RETRY: begin
                    if (w_canRetry) begin
                        r_attempts <= r_attempts + 2'd1;
                        r_rstCnt   <= 1'b0;
                        r_rxState  <= w_rxRetry;
                    end else begin
                        r_fail <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_link_test_ctrl.sv
// tb_link_test_ctrl: table-driven scoreboard bench for link_test_ctrl plus reset corner sequences.
module tb_link_test_ctrl;
    localparam int TIMEOUT_CYCLES = 7936;
`ifdef LINK_TEST_CTRL_SEED_ADVANCE_EN
    localparam bit ADV = 1'b1;
`else
    localparam bit ADV = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        syncFlag = 1'b0;
    logic        endFlag  = 1'b0;
    logic [4:0]  seedIn   = 5'd0;
    logic [14:0] dataIn   = 15'd0;
    logic        linkRst;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [4:0]  txState;
    logic [4:0]  rxState;
    logic [14:0] testData;
    logic [1:0]  attempts;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic [4:0]       seed;
        logic [14:0]      data;
        int               syncAtt;
        int               syncCyc;
        int               endCyc;
        bit               busyStart;
        bit               expPass;
        bit               expFail;
        logic [1:0]       expAtt;
        logic [4:0]       expTx;
        logic [2:0][4:0]  expRx;
        int               expLat;
    } vec_t;

    typedef struct {
        bit          pass;
        bit          fail;
        logic [1:0]  att;
        logic [4:0]  tx;
        logic [14:0] data;
        int          lat;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[6];

    link_test_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed_in    (seedIn),
        .data_in    (dataIn),
        .sync_flag  (syncFlag),
        .end_flag   (endFlag),
        .link_rst   (linkRst),
        .tx_m_state (txState),
        .rx_m_state (rxState),
        .test_data  (testData),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .attempts   (attempts)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Launches one test, drives flags by attempt/RUN cycle, and checks the scoreboard entry at done.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        exp_t got;
        int   runCyc;
        int   att;
        int   pulseW;
        int   pulses;
        int   both;
        bit   prevRst;
        bit   seen;
        e.pass = v.expPass;
        e.fail = v.expFail;
        e.att  = v.expAtt;
        e.tx   = v.expTx;
        e.data = v.data;
        e.lat  = v.expLat;
        scoreboard.push_back(e);
        seedIn = v.seed;
        dataIn = v.data;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("load_busy", 32'(busy), 32'd1);
        checkOutput("load_linkrst", 32'(linkRst), 32'd0);
        runCyc = 0; att = 0; pulseW = 0; pulses = 0; both = 0;
        prevRst = 1'b0; seen = 1'b0;
        for (int cyc = 0; cyc < 30000 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                seedIn = ~v.seed;
                dataIn = ~v.data;
            end
            syncFlag = 1'b0;
            endFlag  = 1'b0;
            start    = 1'b0;
            if (pass && fail) both++;
            if (linkRst) pulseW++;
            if (prevRst && !linkRst) begin
                pulses++;
                att++;
                runCyc = 0;
                checkOutput("rst_width", 32'(pulseW), 32'd2);
                pulseW = 0;
                checkOutput("attempts_run", 32'(attempts), 32'(att));
                if (att >= 1 && att <= 3) begin
                    checkOutput("rx_attempt", 32'(rxState), 32'(v.expRx[2'(att - 1)]));
                end
            end else begin
                runCyc++;
            end
            prevRst = linkRst;
            if (done) begin
                seen = 1'b1;
                if (scoreboard.size() == 0) begin
                    checkOutput("sb_empty", 32'd1, 32'd0);
                end else begin
                    got = scoreboard.pop_front();
                    checkOutput("pass", 32'(pass), 32'(got.pass));
                    checkOutput("fail", 32'(fail), 32'(got.fail));
                    checkOutput("attempts", 32'(attempts), 32'(got.att));
                    checkOutput("tx_state", 32'(txState), 32'(got.tx));
                    checkOutput("test_data", 32'(testData), 32'(got.data));
                    checkOutput("done_latency", 32'(runCyc), 32'(got.lat));
                    checkOutput("rst_pulses", 32'(pulses), 32'(got.att));
                end
                checkOutput("done_busy", 32'(busy), 32'd1);
                checkOutput("exclusive", 32'(both), 32'd0);
            end else if (att > 0 && !linkRst) begin
                if (att == v.syncAtt && runCyc == v.syncCyc) syncFlag = 1'b1;
                if (runCyc == v.endCyc) endFlag = 1'b1;
                if (v.busyStart && att == 1 && runCyc == 2) begin
                    start  = 1'b1;
                    seedIn = 5'h0A;
                    dataIn = 15'h0F0F;
                end
            end
        end
        if (!seen) begin
            checkOutput("done_timeout", 32'd1, 32'd0);
            void'(scoreboard.pop_front());
        end
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("pass_held", 32'(pass), 32'(v.expPass));
        checkOutput("fail_held", 32'(fail), 32'(v.expFail));
    endtask

    initial begin
        bit found;
        int busyCnt;
        vecs[0] = '{5'h1F, 15'h2A5, 1, 100, -1, 1'b1, 1'b1, 1'b0, 2'd1, 5'h1F,
                    {5'h00, 5'h00, 5'h1F}, 101};
        vecs[1] = '{5'h00, 15'h7FFF, 0, -1, 5, 1'b0, 1'b0, 1'b1, 2'd3, 5'h01,
                    ADV ? {5'h04, 5'h02, 5'h01} : {5'h01, 5'h01, 5'h01}, 7};
        vecs[2] = '{5'h12, 15'h1234, 1, 20, 20, 1'b0, 1'b1, 1'b0, 2'd1, 5'h12,
                    {5'h00, 5'h00, 5'h12}, 21};
        vecs[3] = '{5'h05, 15'h0001, 2, 2, 3, 1'b0, 1'b1, 1'b0, 2'd2, 5'h05,
                    ADV ? {5'h00, 5'h0A, 5'h05} : {5'h00, 5'h05, 5'h05}, 3};
        vecs[4] = '{5'h1F, 15'h5555, 0, -1, -1, 1'b0, 1'b0, 1'b1, 2'd3, 5'h1F,
                    ADV ? {5'h1C, 5'h1E, 5'h1F} : {5'h1F, 5'h1F, 5'h1F}, TIMEOUT_CYCLES};
        vecs[5] = '{5'h10, 15'h0000, 3, 0, 1, 1'b0, 1'b1, 1'b0, 2'd3, 5'h10,
                    ADV ? {5'h02, 5'h01, 5'h10} : {5'h10, 5'h10, 5'h10}, 1};

        repeat (2) @(negedge clk);
        checkOutput("rst_linkrst", 32'(linkRst), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        checkOutput("rst_attempts", 32'(attempts), 32'd0);
        checkOutput("rst_tx", 32'(txState), 32'd1);
        checkOutput("rst_rx", 32'(rxState), 32'd1);
        checkOutput("rst_data", 32'(testData), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rel_linkrst", 32'(linkRst), 32'd0);
        checkOutput("rel_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end
        checkOutput("sb_drained", 32'(scoreboard.size()), 32'd0);

        // Asynchronous reset during RUN of attempt 2
        start   = 1'b1;
        seedIn  = 5'h03;
        dataIn  = 15'h0ABC;
        endFlag = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (busy && !linkRst && attempts == 2'd2) found = 1'b1;
        end
        checkOutput("mid_found", 32'(found), 32'd1);
        endFlag = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_linkrst", 32'(linkRst), 32'd1);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_attempts", 32'(attempts), 32'd0);
        checkOutput("mid_tx", 32'(txState), 32'd1);
        checkOutput("mid_rx", 32'(rxState), 32'd1);
        checkOutput("mid_data", 32'(testData), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rel_linkrst", 32'(linkRst), 32'd0);
        busyCnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) busyCnt++;
        end
        checkOutput("mid_no_resume", 32'(busyCnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
